// File: rtl/mem_copy_dma.sv
// mem_copy_dma
// Burst-copy engine on the tagged memory port. Software latches src/dst/len
// with a one-cycle start; the engine then repeats "one tagged burst read into
// a local buffer, then burst_length single-word writes" len times and pulses
// done.
//
// Ports:
//   clock              system clock, all state on posedge
//   rst                asynchronous reset, active low
//   start              one-cycle copy request (only honoured while idle)
//   src, dst           first source / destination word address
//   len                number of bursts to copy (0 = no bus activity)
//   busy, done         status: busy while copying, done pulses at the end
//   mem_waitrequest    responder stall; request accepted on a low posedge
//   mem_id             read tag (dma_id)
//   mem_address        word address of the current request
//   mem_read           burst read request
//   mem_write          single-word write request
//   mem_writedata      write data
//   mem_writedatamask  byte enables, all ones while writing
//   mem_readdata       returned read word
//   mem_readdataid     tag of mem_readdata, 0 = no data this cycle
module mem_copy_dma #(
  parameter int unsigned burst_bits   = 2,
  parameter int unsigned burst_length = 1 << burst_bits,
  parameter logic [1:0]  dma_id       = 2'd3
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] src,
  input  logic [29:0] dst,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  localparam int unsigned WCNT_W = burst_bits + 1;
  localparam logic [WCNT_W-1:0]     WCNT_LAST = WCNT_W'(burst_length - 1);
  localparam logic [WCNT_W-1:0]     WCNT_ONE  = WCNT_W'(1);
  localparam logic [burst_bits-1:0] IDX_ONE   = burst_bits'(1);
  localparam logic [29:0]           ADDR_STEP = 30'(burst_length);
  localparam logic [29:0]           ADDR_ONE  = 30'd1;

  logic [2:0]        state_reg;
  logic [29:0]       sa_reg;
  logic [29:0]       da_reg;
  logic [15:0]       bursts_left_reg;
  logic [WCNT_W-1:0] wcnt_reg;

  logic        busy_reg;
  logic        done_reg;
  logic [1:0]  mem_id_reg;
  logic [29:0] mem_address_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic [31:0] mem_writedata_reg;
  logic [3:0]  mem_writedatamask_reg;

  // Burst buffer: plain storage, never reset. A reset mid-copy simply
  // abandons whatever it holds; every entry is rewritten before it is read.
  logic [31:0] buf_mem [burst_length];

  logic                  capture;
  logic [burst_bits-1:0] wcnt_idx;
  logic [burst_bits-1:0] idx_next;

  assign capture  = (state_reg == RD_DATA) && (mem_readdataid == dma_id);
  assign wcnt_idx = wcnt_reg[burst_bits-1:0];
  assign idx_next = wcnt_idx + IDX_ONE;

  generate
    for (genvar gi = 0; gi < burst_length; gi++) begin : g_buf
      always_ff @(posedge clock) begin
        if (capture && (wcnt_idx == burst_bits'(gi))) begin
          buf_mem[gi] <= mem_readdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg             <= IDLE;
      sa_reg                <= '0;
      da_reg                <= '0;
      bursts_left_reg       <= '0;
      wcnt_reg              <= '0;
      busy_reg              <= 1'b0;
      done_reg              <= 1'b0;
      mem_id_reg            <= '0;
      mem_address_reg       <= '0;
      mem_read_reg          <= 1'b0;
      mem_write_reg         <= 1'b0;
      mem_writedata_reg     <= '0;
      mem_writedatamask_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sa_reg          <= src;
            da_reg          <= dst;
            bursts_left_reg <= len;
            if (len == 16'd0) begin
              state_reg <= FIN;
            end else begin
              busy_reg        <= 1'b1;
              mem_read_reg    <= 1'b1;
              mem_id_reg      <= dma_id;
              mem_address_reg <= src;
              state_reg       <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          if (!mem_waitrequest) begin
            mem_read_reg <= 1'b0;
            wcnt_reg     <= '0;
            state_reg    <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (capture) begin
            if (wcnt_reg == WCNT_LAST) begin
              sa_reg                <= sa_reg + ADDR_STEP;
              wcnt_reg              <= '0;
              state_reg             <= WR;
              mem_write_reg         <= 1'b1;
              mem_address_reg       <= da_reg;
              mem_writedatamask_reg <= 4'hF;
              // With a one-word burst the first word is the one arriving now
              // and has not reached the buffer yet.
              mem_writedata_reg     <= (wcnt_reg == '0) ? mem_readdata : buf_mem[0];
            end else begin
              wcnt_reg <= wcnt_reg + WCNT_ONE;
            end
          end
        end

        WR: begin
          if (!mem_waitrequest) begin
            da_reg <= da_reg + ADDR_ONE;
            if (wcnt_reg == WCNT_LAST) begin
              mem_write_reg         <= 1'b0;
              mem_writedatamask_reg <= 4'h0;
              wcnt_reg              <= '0;
              bursts_left_reg       <= bursts_left_reg - 16'd1;
              if (bursts_left_reg == 16'd1) begin
                state_reg <= FIN;
              end else begin
                // sa_reg already points at the next burst.
                state_reg       <= RD_REQ;
                mem_read_reg    <= 1'b1;
                mem_address_reg <= sa_reg;
              end
            end else begin
              wcnt_reg          <= wcnt_reg + WCNT_ONE;
              mem_address_reg   <= da_reg + ADDR_ONE;
              mem_writedata_reg <= buf_mem[idx_next];
            end
          end
        end

        FIN: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign mem_id            = mem_id_reg;
  assign mem_address       = mem_address_reg;
  assign mem_read          = mem_read_reg;
  assign mem_write         = mem_write_reg;
  assign mem_writedata     = mem_writedata_reg;
  assign mem_writedatamask = mem_writedatamask_reg;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma. A behavioural responder (inside step())
// answers reads with tagged beats from a small memory model, logs every
// accepted read/write and can stall requests on demand.
module tb_mem_copy_dma;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [29:0] src = '0;
  logic [29:0] dst = '0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        mem_waitrequest = 1'b0;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata = '0;
  logic [1:0]  mem_readdataid = '0;

  mem_copy_dma dut (
    .clock             (clock),
    .rst               (rst),
    .start             (start),
    .src               (src),
    .dst               (dst),
    .len               (len),
    .busy              (busy),
    .done              (done),
    .mem_waitrequest   (mem_waitrequest),
    .mem_id            (mem_id),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_writedatamask (mem_writedatamask),
    .mem_readdata      (mem_readdata),
    .mem_readdataid    (mem_readdataid)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [1:0] id; logic [31:0] data; } beat_t;
  typedef struct packed { logic [29:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [logic [29:0]];
  beat_t       beat_q [$];
  wr_t         wr_log [$];
  logic [29:0] rd_log [$];
  logic [31:0] exp_data [$];

  int cyc = 0, start_cyc = 0, done_cyc = 0, done_count = 0;
  int activity = 0, rw_overlap = 0, rd_overlap = 0, bad_id = 0, dead_writes = 0;
  int rd_stall_left = 0, wr_stall_left = 0, wr_stall_idx = -1, wr_seen = 0;
  int stall_cycles = 0, stall_events = 0, stall_viol = 0;
  bit foreign_mode = 0, gap_mode = 0, in_stall = 0;
  logic [29:0] stall_addr;
  logic [31:0] stall_data;
  logic [1:0]  stall_rw;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [29:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {2'b01, a};
  endfunction

  // One clock of the responder: runs at the falling edge, looks at the DUT
  // requests and sets up waitrequest / read beats for the next rising edge.
  task automatic step();
    beat_t b;
    logic  stall;
    @(negedge clock);
    cyc++;
    if (!rst) begin
      beat_q.delete();
      mem_waitrequest = 1'b0;
      mem_readdataid  = 2'd0;
      mem_readdata    = 32'h0;
      in_stall        = 0;
      return;
    end
    if (done) begin done_count++; done_cyc = cyc; end
    if (mem_read || mem_write) activity++;
    if (mem_read && mem_write) rw_overlap++;
    if (mem_read && beat_q.size() != 0) rd_overlap++;
    if (beat_q.size() != 0) begin
      b = beat_q.pop_front();
      mem_readdataid = b.id;
      mem_readdata   = b.data;
    end else begin
      mem_readdataid = 2'd0;
      mem_readdata   = 32'h0BAD_F00D;
    end
    stall = 1'b0;
    if (mem_read && rd_stall_left > 0) begin
      rd_stall_left--; stall = 1'b1;
    end else if (mem_write && wr_seen == wr_stall_idx && wr_stall_left > 0) begin
      wr_stall_left--; stall = 1'b1;
    end
    if (stall) begin
      stall_cycles++;
      mem_waitrequest = 1'b1;
      if (!in_stall) begin
        in_stall = 1; stall_addr = mem_address; stall_data = mem_writedata;
        stall_rw = {mem_read, mem_write};
      end else if (mem_address != stall_addr || stall_rw != {mem_read, mem_write} ||
                   (mem_write && mem_writedata != stall_data)) begin
        stall_viol++;
      end
    end else begin
      mem_waitrequest = 1'b0;
      if (in_stall) begin
        if (mem_address != stall_addr || stall_rw != {mem_read, mem_write} ||
            (mem_write && mem_writedata != stall_data)) stall_viol++;
        stall_events++;
        in_stall = 0;
      end
      if (mem_read) begin
        rd_log.push_back(mem_address);
        if (mem_id != 2'd3) bad_id++;
        $display("[%0d] RD addr=0x%08h id=%0d", cyc, mem_address, mem_id);
        for (int i = 0; i < 4; i++) begin
          if (gap_mode) begin b.id = 2'd0; b.data = 32'h0; beat_q.push_back(b); end
          b.id = 2'd3; b.data = rd_word(mem_address + 30'(i)); beat_q.push_back(b);
          if (foreign_mode && i < 3) begin b.id = 2'd1; b.data = 32'hDEAD; beat_q.push_back(b); end
        end
      end else if (mem_write) begin
        wr_t w;
        w.addr = mem_address; w.data = mem_writedata; w.mask = mem_writedatamask;
        wr_log.push_back(w);
        wr_seen++;
        if (mem_writedata == 32'hDEAD) dead_writes++;
        $display("[%0d] WR addr=0x%08h data=0x%08h mask=%h", cyc, mem_address, mem_writedata, mem_writedatamask);
      end
    end
  endtask

  task automatic start_copy(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n);
    rd_log.delete(); wr_log.delete();
    done_count = 0; wr_seen = 0; activity = 0; rw_overlap = 0; rd_overlap = 0;
    bad_id = 0; dead_writes = 0; stall_cycles = 0; stall_events = 0; stall_viol = 0;
    src = s; dst = d; len = n; start = 1'b1; start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done_count == 0; i++) step();
    repeat (3) step();
    check_val({tag, "_done_once"}, done_count, 1);
    check_val({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic verify_writes(input string tag, input logic [29:0] dst_base);
    check_val({tag, "_wr_count"}, wr_log.size(), exp_data.size());
    for (int i = 0; i < wr_log.size() && i < exp_data.size(); i++) begin
      check_val($sformatf("%s_wr%0d_addr", tag, i), wr_log[i].addr, dst_base + 30'(i));
      check_val($sformatf("%s_wr%0d_data", tag, i), wr_log[i].data, exp_data[i]);
      check_val($sformatf("%s_wr%0d_mask", tag, i), wr_log[i].mask, 4'hF);
    end
    check_val({tag, "_rw_overlap"}, rw_overlap, 0);
    check_val({tag, "_read_while_pending"}, rd_overlap, 0);
    check_val({tag, "_read_id"}, bad_id, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ctrl"}, {busy, done, mem_read, mem_write, mem_id, mem_writedatamask}, 10'h0);
    check_val({tag, "_addr"}, mem_address, 30'h0);
    check_val({tag, "_wdata"}, mem_writedata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem_model[30'h100 + 30'(i)] = 32'hA0 + 32'(i);

    step(); step();
    check_idle_outputs("reset");
    rst = 1'b1;
    step();

    // Single burst
    start_copy(30'h100, 30'h200, 16'd1);
    check_val("single_busy_after_start", busy, 1);
    wait_done("single");
    check_val("single_rd_count", rd_log.size(), 1);
    if (rd_log.size() > 0) check_val("single_rd_addr", rd_log[0], 30'h100);
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    verify_writes("single", 30'h200);

    // Zero length
    start_copy(30'h123, 30'h456, 16'd0);
    check_val("zero_busy", busy, 0);
    wait_done("zero");
    check_val("zero_done_latency", done_cyc - start_cyc, 2);
    check_val("zero_activity", activity, 0);

    // Stall hold on the read request and the third write
    rd_stall_left = 5; wr_stall_idx = 2; wr_stall_left = 5;
    start_copy(30'h40, 30'h80, 16'd1);
    wait_done("stall");
    check_val("stall_rd_count", rd_log.size(), 1);
    if (rd_log.size() > 0) check_val("stall_rd_addr", rd_log[0], 30'h40);
    check_val("stall_cycles", stall_cycles, 10);
    check_val("stall_events", stall_events, 2);
    check_val("stall_stable", stall_viol, 0);
    exp_data = '{32'h40000040, 32'h40000041, 32'h40000042, 32'h40000043};
    verify_writes("stall", 30'h80);
    wr_stall_idx = -1;

    // Foreign tags interleaved with idle beats
    foreign_mode = 1; gap_mode = 1;
    start_copy(30'h300, 30'h380, 16'd1);
    wait_done("foreign");
    check_val("foreign_dead_writes", dead_writes, 0);
    exp_data = '{32'h40000300, 32'h40000301, 32'h40000302, 32'h40000303};
    verify_writes("foreign", 30'h380);
    foreign_mode = 0; gap_mode = 0;

    // Two bursts, source wraps past the top of the address space
    start_copy(30'h3FFFFFFE, 30'h10, 16'd2);
    wait_done("wrap");
    check_val("wrap_rd_count", rd_log.size(), 2);
    if (rd_log.size() > 1) begin
      check_val("wrap_rd0_addr", rd_log[0], 30'h3FFFFFFE);
      check_val("wrap_rd1_addr", rd_log[1], 30'h00000002);
    end
    exp_data = '{32'h7FFFFFFE, 32'h7FFFFFFF, 32'h40000000, 32'h40000001,
                 32'h40000002, 32'h40000003, 32'h40000004, 32'h40000005};
    verify_writes("wrap", 30'h10);

    // Reset during the second write of the first burst of a 3-burst copy
    wr_stall_idx = 1; wr_stall_left = 3;
    start_copy(30'h500, 30'h600, 16'd3);
    for (int i = 0; i < 200 && wr_seen < 1; i++) step();
    step();
    check_val("rst_pre_write", mem_write, 1);
    check_val("rst_pre_addr", mem_address, 30'h601);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    step(); step();
    check_val("rst_done_low", done, 0);
    rst = 1'b1; wr_stall_idx = -1; wr_stall_left = 0;
    repeat (5) step();
    check_val("rst_no_done", done_count, 0);
    check_val("rst_writes_before", wr_log.size(), 1);

    start_copy(30'h100, 30'h700, 16'd1);
    wait_done("after_rst");
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    verify_writes("after_rst", 30'h700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
